uart_tx_arbiter: RTL and testbench



---
 rtl/uart_pkg.sv | 39 +++
 rtl/rr_arbiter_onehot.sv | 57 +++++
 rtl/uart_tx_arbiter.sv | 119 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmit arbiter:
//   - FSM state encoding for the arbiter controller
//   - BYTE_W, the width of one UART payload byte
//   - rr_pick(), a round-robin one-hot winner search used by rr_arbiter_onehot
package uart_pkg;

    localparam int BYTE_W  = 8;
    // rr_pick works on a fixed-width vector; callers zero-pad narrower requests.
    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Returns a one-hot vector selecting the first set bit of valid, searching
    // upward from pointer+1 and wrapping modulo nreq. All zero if none is set.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input int                 pointer,
        input int                 nreq
    );
        logic [MAX_REQ-1:0] win;
        int                 idx;
        win = '0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            if (k <= nreq && win == '0) begin
                idx = (pointer + k) % nreq;
                if (valid[idx[2:0]]) begin
                    win[idx[2:0]] = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_arbiter_onehot.sv
// rr_arbiter_onehot
// Combinational round-robin picker with a registered priority pointer.
// The pointer remembers the last winner, so that requester has the lowest
// priority at the next pick.
// Ports:
//   clk, reset   clock and synchronous active-high reset (pointer -> NREQ-1)
//   valid        request vector
//   advance      load the current winner into the pointer (when any is set)
//   winner       one-hot winner for the current valid vector
//   winner_idx   binary index of winner
//   any          at least one request is valid
module rr_arbiter_onehot
    import uart_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] valid,
    input  logic            advance,
    output logic [NREQ-1:0] winner,
    output logic [PW-1:0]   winner_idx,
    output logic            any
);

    logic [PW-1:0]      ptr;
    logic [MAX_REQ-1:0] valid_ext;
    logic [MAX_REQ-1:0] pick;
    logic               unused_pick;

    always_comb begin
        valid_ext             = '0;
        valid_ext[NREQ-1:0]   = valid;
        pick                  = rr_pick(valid_ext, int'(ptr), NREQ);
        winner                = pick[NREQ-1:0];
        winner_idx            = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner[i]) begin
                winner_idx = PW'(i);
            end
        end
        any = |valid;
    end

    // Upper pick bits are always zero when NREQ < MAX_REQ.
    assign unused_pick = ^pick;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= PW'(NREQ - 1);
        end else if (advance && any) begin
            ptr <= winner_idx;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one uart_tx byte transmitter among NREQ byte sources. Grants are
// round-robin and packet-atomic: an owner keeps the UART until it sends a
// byte marked last, or until MAX_BURST bytes (0 = unlimited).
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   req_valid    per-requester byte pending
//   req_data     per-requester byte, requester i in [8i+7:8i]
//   req_last     per-requester end-of-packet marker
//   req_ack      one-cycle pulse: requester's byte was taken
//   grant        one-hot current owner, zero when idle
//   busy         a grant is held
//   tx_data      byte to uart_tx, held between strobes
//   tx_strobe    one-cycle load pulse to uart_tx
//   tx_ready     uart_tx can accept a byte
//
// state | meaning
// IDLE  | no owner; arbitrate among valid requesters
// SEND  | owner holds the UART; wait for tx_ready and owner's valid
// GAP   | one cycle after a strobe; release or return to SEND
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NREQ      = 4,
    parameter  int MAX_BURST = 0,
    parameter  int CW        = 8,
    localparam int PW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [BYTE_W*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]        req_last,
    output logic [NREQ-1:0]        req_ack,
    output logic [NREQ-1:0]        grant,
    output logic                   busy,
    output logic [BYTE_W-1:0]      tx_data,
    output logic                   tx_strobe,
    input  logic                   tx_ready
);

    state_t            state;
    logic [CW-1:0]     count;
    logic              last_seen;
    logic [PW-1:0]     gidx;
    logic [NREQ-1:0]   arb_winner;
    logic [PW-1:0]     arb_idx;
    logic              arb_any;
    logic              burst_done;
    logic [BYTE_W-1:0] data_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_split
        assign data_arr[i] = req_data[i*BYTE_W +: BYTE_W];
    end

    rr_arbiter_onehot #(.NREQ(NREQ)) u_arb (
        .clk        (clk),
        .reset      (reset),
        .valid      (req_valid),
        .advance    (state == IDLE),
        .winner     (arb_winner),
        .winner_idx (arb_idx),
        .any        (arb_any)
    );

    assign burst_done = (MAX_BURST != 0) && (count == CW'(MAX_BURST));

    // GAP exists so the tx_ready sampled in SEND is never the stale value
    // from the cycle right after a strobe, before uart_tx has reacted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            busy      <= 1'b0;
            req_ack   <= '0;
            tx_strobe <= 1'b0;
            tx_data   <= '0;
            count     <= '0;
            last_seen <= 1'b0;
            gidx      <= '0;
        end else begin
            req_ack   <= '0;
            tx_strobe <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (arb_any) begin
                        grant <= arb_winner;
                        gidx  <= arb_idx;
                        busy  <= 1'b1;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (tx_ready && req_valid[gidx]) begin
                        tx_data   <= data_arr[gidx];
                        tx_strobe <= 1'b1;
                        req_ack   <= grant;
                        count     <= count + CW'(1);
                        last_seen <= req_last[gidx];
                        state     <= GAP;
                    end
                end
                GAP: begin
                    if (last_seen || burst_done) begin
                        grant     <= '0;
                        busy      <= 1'b0;
                        count     <= '0;
                        last_seen <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        state <= SEND;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Directed scenarios followed by a randomized run. Requesters are modelled as
// per-requester byte queues; a transaction-level reference predicts the owner
// of every grant, when strobes must appear, which byte each strobe carries,
// and when a grant is released.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int MB   = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ack;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic [7:0]        tx_data;
    logic              tx_strobe;
    logic              tx_ready;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NREQ(NREQ), .MAX_BURST(MB), .CW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ack   (req_ack),
        .grant     (grant),
        .busy      (busy),
        .tx_data   (tx_data),
        .tx_strobe (tx_strobe),
        .tx_ready  (tx_ready)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [8:0]      q [NREQ][$];   // {last, data}
    logic [NREQ-1:0] hold;

    int         owner, ptr, grant_cyc, last_strobe, nbytes;
    bit         rel_pending;
    logic [7:0] last_data;

    int         slog_cyc[$];
    int         slog_own[$];
    logic [7:0] slog_dat[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic int rr_expect(input logic [NREQ-1:0] v, input int p);
        int idx;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (p + k) % NREQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic bit pending();
        for (int i = 0; i < NREQ; i++)
            if (q[i].size() > 0 && !hold[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (q[i].size() > 0) begin
                req_valid[i]       = !hold[i];
                req_data[i*8 +: 8] = q[i][0][7:0];
                req_last[i]        = q[i][0][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        owner       = -1;
        ptr         = NREQ - 1;
        grant_cyc   = 0;
        last_strobe = -100;
        nbytes      = 0;
        rel_pending = 1'b0;
        last_data   = 8'h00;
    endtask

    task automatic clear_log();
        slog_cyc.delete();
        slog_own.delete();
        slog_dat.delete();
    endtask

    // One clock with reference-model checking, then requesters react.
    task automatic step();
        logic [NREQ-1:0] dv;
        logic            dr;
        logic            exp_strobe;
        logic [NREQ-1:0] exp_grant;
        int              w;
        dv = req_valid;
        dr = tx_ready;
        @(posedge clk);
        #1;
        cyc++;
        exp_strobe = 1'b0;
        if (owner < 0) begin
            w = rr_expect(dv, ptr);
            if (w >= 0) begin
                owner       = w;
                ptr         = w;
                grant_cyc   = cyc;
                nbytes      = 0;
                rel_pending = 1'b0;
            end
        end else if (cyc == last_strobe + 1) begin
            if (rel_pending) owner = -1;
        end else if (dr && dv[owner]) begin
            exp_strobe = 1'b1;
        end
        exp_grant = '0;
        if (owner >= 0) exp_grant[owner] = 1'b1;
        chk("grant", grant, exp_grant);
        chk("busy", busy, owner >= 0);
        chk("tx_strobe", tx_strobe, exp_strobe);
        if (exp_strobe) begin
            chk("tx_data", tx_data, q[owner][0][7:0]);
            chk("req_ack", req_ack, exp_grant);
            slog_cyc.push_back(cyc);
            slog_own.push_back(owner);
            slog_dat.push_back(q[owner][0][7:0]);
            last_data   = q[owner][0][7:0];
            nbytes++;
            rel_pending = q[owner][0][8] || (nbytes == MB);
            last_strobe = cyc;
            void'(q[owner].pop_front());
        end else begin
            chk("req_ack_idle", req_ack, '0);
            chk("tx_data_hold", tx_data, last_data);
        end
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        chk("rst_grant", grant, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ack", req_ack, '0);
        chk("rst_strobe", tx_strobe, 1'b0);
        chk("rst_data", tx_data, 8'h00);
        reset = 1'b0;
        model_reset();
        drive();
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while ((pending() || owner >= 0) && n < bound) begin
            step();
            n++;
        end
        chk("drain_bound", n < bound, 1'b1);
    endtask

    initial begin
        int         start;
        int         rise;
        int         n;
        int         len;
        int         r;
        logic [7:0] hi_b [3];
        int         burst_own [9];
        int         drop_own [4];

        hi_b      = '{8'h48, 8'h69, 8'h0A};
        burst_own = '{1, 1, 1, 3, 1, 1, 1, 3, 1};
        drop_own  = '{1, 1, 1, 2};

        reset     = 1'b1;
        tx_ready  = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        hold      = '0;
        model_reset();
        do_reset();

        // "Hi\n" from requester 0 with tx_ready high
        tx_ready = 1'b1;
        clear_log();
        q[0].push_back({1'b0, 8'h48});
        q[0].push_back({1'b0, 8'h69});
        q[0].push_back({1'b1, 8'h0A});
        start = cyc;
        drive();
        drain(40);
        chk("hi_count", slog_cyc.size(), 3);
        for (int k = 0; k < 3 && k < slog_cyc.size(); k++) begin
            chk("hi_byte", slog_dat[k], hi_b[k]);
            chk("hi_time", slog_cyc[k] - start, 2 + 2 * k);
        end
        chk("hi_release", grant, '0);

        // Requesters 0 and 2 alternate with one-byte packets
        do_reset();
        clear_log();
        for (int k = 0; k < 4; k++) begin
            q[0].push_back({1'b1, 8'h10 + 8'(k)});
            q[2].push_back({1'b1, 8'h20 + 8'(k)});
        end
        drive();
        drain(100);
        chk("rr_count", slog_own.size(), 8);
        for (int k = 0; k < 8 && k < slog_own.size(); k++)
            chk("rr_order", slog_own[k], (k % 2 == 1) ? 2 : 0);

        // tx_ready held low while granted
        clear_log();
        tx_ready = 1'b0;
        q[1].push_back({1'b0, 8'hA1});
        q[1].push_back({1'b1, 8'hA2});
        drive();
        repeat (100) step();
        chk("stall_nostrobe", slog_cyc.size(), 0);
        chk("stall_grant", grant, 4'b0010);
        tx_ready = 1'b1;
        rise = cyc;
        step();
        chk("ready_strobe", slog_cyc.size(), 1);
        if (slog_cyc.size() > 0) chk("ready_lat", slog_cyc[0] - rise, 1);
        drain(40);

        // Burst limit: requester 1 sends 7 bytes, requester 3 interleaves
        do_reset();
        clear_log();
        for (int k = 0; k < 7; k++)
            q[1].push_back({(k == 6), 8'h30 + 8'(k)});
        q[3].push_back({1'b1, 8'hC0});
        q[3].push_back({1'b1, 8'hC1});
        drive();
        drain(200);
        chk("burst_count", slog_own.size(), 9);
        for (int k = 0; k < 9 && k < slog_own.size(); k++)
            chk("burst_order", slog_own[k], burst_own[k]);

        // Reset in GAP mid-packet; requester 0 must win first afterwards
        clear_log();
        q[2].push_back({1'b0, 8'h51});
        q[2].push_back({1'b0, 8'h52});
        q[2].push_back({1'b1, 8'h53});
        drive();
        n = 0;
        while (slog_cyc.size() == 0 && n < 20) begin
            step();
            n++;
        end
        chk("gap_reach", slog_cyc.size(), 1);
        q[0].push_back({1'b1, 8'h77});
        drive();
        do_reset();
        step();
        chk("post_reset_owner", grant, 4'b0001);
        drain(60);

        // Owner drops valid mid-packet for 10 cycles
        do_reset();
        clear_log();
        q[1].push_back({1'b0, 8'h61});
        q[1].push_back({1'b0, 8'h62});
        q[1].push_back({1'b1, 8'h63});
        q[2].push_back({1'b1, 8'h64});
        drive();
        n = 0;
        while (slog_cyc.size() == 0 && n < 20) begin
            step();
            n++;
        end
        hold[1] = 1'b1;
        drive();
        repeat (10) step();
        chk("drop_nostrobe", slog_cyc.size(), 1);
        chk("drop_grant", grant, 4'b0010);
        hold = '0;
        drive();
        drain(60);
        chk("drop_count", slog_own.size(), 4);
        for (int k = 0; k < 4 && k < slog_own.size(); k++)
            chk("drop_order", slog_own[k], drop_own[k]);

        // Randomized traffic, ready and valid stalls
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            r = int'($urandom_range(0, 99));
            if (r < 15) begin
                r = int'($urandom_range(0, NREQ - 1));
                if (q[r].size() < 10) begin
                    len = int'($urandom_range(1, 5));
                    for (int b = 0; b < len; b++)
                        q[r].push_back({(b == len - 1), 8'($urandom)});
                end
            end
            tx_ready = ($urandom_range(0, 99) < 80);
            if ($urandom_range(0, 99) < 5)
                hold[$urandom_range(0, NREQ - 1)] ^= 1'b1;
            drive();
            step();
        end
        hold     = '0;
        tx_ready = 1'b1;
        drive();
        drain(2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
